amo_issue_ctrl: RTL and testbench
=================================

# amo_issue_ctrl

Sequencer for the LSU atomic-memory-operation path. It sits between the single-entry AMO buffer and the D-cache AMO port. Once the buffered AMO is the committing instruction and the LSQ has drained, it issues exactly one AMO request to the cache, waits for the cache acknowledge, and pops the buffer. It then presents the size-adjusted result to the writeback stage through a valid/ready handshake.

## Interface
- `PLEN`, default 56: physical address width.
- `XLEN`, default 64: data width.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit. Used only when `AMO_TIMEOUT_EN` is defined.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `amo_valid_i`  in  1  buffer holds an AMO (buffer full).
- `amo_op_i`  in  4  ariane AMO opcode of the buffered entry.
- `amo_paddr_i`  in  PLEN  physical address.
- `amo_data_i`  in  XLEN  store operand.
- `amo_size_i`  in  2  access size: 2'b10 is word, 2'b11 is doubleword.
- `commit_i`  in  1  the AMO is the oldest instruction and may execute.
- `no_mem_ops_pending_i`  in  1  LSQ is drained.
- `flush_i`  in  1  pipeline flush.
- `amo_pop_o`  out  1  one-cycle pop to the buffer.
- `amo_req_o`  out  1  cache request valid.
- `amo_req_op_o`  out  4  opcode to cache.
- `amo_req_addr_o`  out  PLEN  operand_a (address).
- `amo_req_data_o`  out  XLEN  operand_b (data).
- `amo_req_size_o`  out  2  size to cache.
- `amo_ack_i`  in  1  cache acknowledge; result valid in the same cycle.
- `amo_result_i`  in  XLEN  cache result.
- `wb_valid_o`  out  1  result valid to writeback.
- `wb_data_o`  out  XLEN  result.
- `wb_ready_i`  in  1  writeback accepts.
- `busy_o`  out  1  controller is not in IDLE.
- `amo_timeout_o`  out  1  sticky watchdog flag. Present only when `AMO_TIMEOUT_EN` is defined.

## Operation
- States: IDLE, DRAIN, ISSUE, WB.
- IDLE to DRAIN: when `amo_valid_i` and `commit_i`, and no flush.
- DRAIN to ISSUE: when `no_mem_ops_pending_i`. On entry to ISSUE, latch op, addr, data and size into request registers.
- DRAIN to IDLE: on `flush_i`. Nothing is sent and there is no pop.
- ISSUE:
  - `amo_req_o` = 1; request fields are stable from the latched registers.
  - On `amo_ack_i`:
    - `amo_pop_o` = 1 for that cycle.
    - Capture the result.
    - Go to WB.
- Result formatting: if size is 2'b10, `wb_data_o` = sign-extension of `amo_result_i[31:0]`; otherwise it is the full 64 bits.
- WB: `wb_valid_o` = 1 until `wb_ready_i`, then go to IDLE.
- Flush in ISSUE or WB: the request is never withdrawn once issued; the access has side effects.
  - A `kill` flag is set.
  - In WB, `wb_valid_o` is suppressed while `kill` is set, and the state returns to IDLE the next cycle.
  - `kill` clears on IDLE entry.
- Opcode AMO_NONE in the buffer: skip ISSUE. Pop in the DRAIN-exit cycle and return to IDLE; no writeback.

## Timing
- All outputs reset to 0 and the state resets to IDLE. The reset is asynchronous and takes effect mid-transaction: an in-flight request is dropped with no pop.
- Minimum latency, from `commit_i` with a drained LSQ to `wb_valid_o`, with immediate ack: 3 cycles.
  - Cycle 0: IDLE to DRAIN.
  - Cycle 1: DRAIN to ISSUE.
  - Cycle 2: req and ack; pop.
  - Cycle 3: WB.
- `amo_req_o` never deasserts before ack. Fields do not change while `amo_req_o` is high.
- Exactly one `amo_pop_o` per issued AMO, coincident with the ack.
- An ack outside ISSUE is ignored.
- `flush_i` and `amo_ack_i` in the same ISSUE cycle: the pop still occurs, WB is entered with `kill` set, and there is no `wb_valid_o`.
- `busy_o` is purely combinational from the state.

## Configuration
- `AMO_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on ISSUE entry and increments each ISSUE cycle without ack.
  - Reaching `TIMEOUT_CYCLES` sets `amo_timeout_o`. The flag is sticky until reset.
  - The request stays asserted.
- `AMO_TIMEOUT_EN` undefined: no counter and no `amo_timeout_o` port.

## Test plan
- Basic AMOADD.D: `amo_valid_i`=1, `commit_i`=1, drained, addr 0x8000_0040, data 5. Ack in the first ISSUE cycle with result 0x7. Expect:
  - one req with those fields;
  - a pop in the ack cycle;
  - `wb_data_o`=0x7 three cycles after commit.
- Word sign-extension: AMOSWAP.W with result 0x0000_0000_8000_0001. Expect `wb_data_o` = 0xFFFF_FFFF_8000_0001.
- Drain stall: `no_mem_ops_pending_i`=0 for 10 cycles. Expect no req during those cycles; the req rises the cycle after drain.
- Flush:
  - In DRAIN: return to IDLE with no req and no pop.
  - In ISSUE with ack 4 cycles later: req held, one pop, no `wb_valid_o`, back to IDLE.
- Writeback backpressure: `wb_ready_i`=0 for 5 cycles. Expect `wb_valid_o` and the data held stable, then IDLE the cycle after ready.
- Watchdog, with `AMO_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: withhold ack. Expect `amo_timeout_o` to rise after 8 ISSUE cycles and remain set after a later ack.

Source files
------------

// File: rtl/amo_issue_ctrl.sv
// AMO issue sequencer between the single-entry AMO buffer and the D-cache AMO port.
// Optional watchdog (counter + sticky amo_timeout_o) is built when AMO_TIMEOUT_EN is defined.
module amo_issue_ctrl #(
  parameter int unsigned PLEN           = 56,
  parameter int unsigned XLEN           = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            amo_valid_i,
  input  logic [3:0]      amo_op_i,
  input  logic [PLEN-1:0] amo_paddr_i,
  input  logic [XLEN-1:0] amo_data_i,
  input  logic [1:0]      amo_size_i,
  input  logic            commit_i,
  input  logic            no_mem_ops_pending_i,
  input  logic            flush_i,
  output logic            amo_pop_o,
  output logic            amo_req_o,
  output logic [3:0]      amo_req_op_o,
  output logic [PLEN-1:0] amo_req_addr_o,
  output logic [XLEN-1:0] amo_req_data_o,
  output logic [1:0]      amo_req_size_o,
  input  logic            amo_ack_i,
  input  logic [XLEN-1:0] amo_result_i,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_data_o,
  input  logic            wb_ready_i,
  output logic            busy_o
`ifdef AMO_TIMEOUT_EN
  ,
  output logic            amo_timeout_o
`endif
);

  typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, WB} state_e;

  localparam logic [3:0] AMO_NONE = 4'b0000;

  state_e          state;
  logic            kill;
  logic [XLEN-1:0] result_fmt;
  logic            drain_exit;

`ifdef AMO_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_cnt;
`endif

  assign busy_o     = (state != IDLE);
  assign drain_exit = (state == DRAIN) && no_mem_ops_pending_i && !flush_i;

  // The pop must line up with the cache ack (or the AMO_NONE drain exit), so it is decoded, not registered.
  assign amo_pop_o = ((state == ISSUE) && amo_ack_i) ||
                     (drain_exit && (amo_op_i == AMO_NONE));

  always_comb begin
    result_fmt = amo_result_i;
    if (amo_req_size_o == 2'b10) begin
      result_fmt = {{(XLEN-32){amo_result_i[31]}}, amo_result_i[31:0]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      kill           <= 1'b0;
      amo_req_o      <= 1'b0;
      amo_req_op_o   <= '0;
      amo_req_addr_o <= '0;
      amo_req_data_o <= '0;
      amo_req_size_o <= '0;
      wb_valid_o     <= 1'b0;
      wb_data_o      <= '0;
`ifdef AMO_TIMEOUT_EN
      tmo_cnt        <= '0;
      amo_timeout_o  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (amo_valid_i && commit_i && !flush_i) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (flush_i) begin
            state <= IDLE;
          end else if (no_mem_ops_pending_i) begin
            if (amo_op_i == AMO_NONE) begin
              state <= IDLE;
            end else begin
              state          <= ISSUE;
              amo_req_o      <= 1'b1;
              amo_req_op_o   <= amo_op_i;
              amo_req_addr_o <= amo_paddr_i;
              amo_req_data_o <= amo_data_i;
              amo_req_size_o <= amo_size_i;
`ifdef AMO_TIMEOUT_EN
              tmo_cnt        <= '0;
`endif
            end
          end
        end
        // Once issued the access has side effects, so a flush only marks the result as dead.
        ISSUE: begin
          if (flush_i) begin
            kill <= 1'b1;
          end
          if (amo_ack_i) begin
            state      <= WB;
            amo_req_o  <= 1'b0;
            wb_data_o  <= result_fmt;
            wb_valid_o <= !(kill || flush_i);
          end
`ifdef AMO_TIMEOUT_EN
          else begin
            if (tmo_cnt != TMO_MAX) begin
              tmo_cnt <= tmo_cnt + CW'(1);
            end
            if (tmo_cnt == TMO_LAST) begin
              amo_timeout_o <= 1'b1;
            end
          end
`endif
        end
        WB: begin
          if (kill || wb_ready_i) begin
            state      <= IDLE;
            kill       <= 1'b0;
            wb_valid_o <= 1'b0;
          end else if (flush_i) begin
            kill       <= 1'b1;
            wb_valid_o <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amo_issue_ctrl.sv
// Randomized bench for amo_issue_ctrl: transaction-level expectations derived from planned timings.
module tb_amo_issue_ctrl;
  localparam int PLEN = 56;
  localparam int XLEN = 64;
  localparam int TMO  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            amo_valid = 1'b0;
  logic [3:0]      amo_op = '0;
  logic [PLEN-1:0] amo_paddr = '0;
  logic [XLEN-1:0] amo_data = '0;
  logic [1:0]      amo_size = '0;
  logic            commit = 1'b0;
  logic            pending_n = 1'b0;
  logic            flush = 1'b0;
  logic            amo_pop;
  logic            amo_req;
  logic [3:0]      amo_req_op;
  logic [PLEN-1:0] amo_req_addr;
  logic [XLEN-1:0] amo_req_data;
  logic [1:0]      amo_req_size;
  logic            amo_ack = 1'b0;
  logic [XLEN-1:0] amo_result = '0;
  logic            wb_valid;
  logic [XLEN-1:0] wb_data;
  logic            wb_ready = 1'b0;
  logic            busy;
`ifdef AMO_TIMEOUT_EN
  logic            amo_timeout;
`endif

  amo_issue_ctrl #(.PLEN(PLEN), .XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .amo_valid_i(amo_valid), .amo_op_i(amo_op),
    .amo_paddr_i(amo_paddr), .amo_data_i(amo_data), .amo_size_i(amo_size),
    .commit_i(commit), .no_mem_ops_pending_i(pending_n), .flush_i(flush),
    .amo_pop_o(amo_pop), .amo_req_o(amo_req), .amo_req_op_o(amo_req_op),
    .amo_req_addr_o(amo_req_addr), .amo_req_data_o(amo_req_data),
    .amo_req_size_o(amo_req_size), .amo_ack_i(amo_ack), .amo_result_i(amo_result),
    .wb_valid_o(wb_valid), .wb_data_o(wb_data), .wb_ready_i(wb_ready), .busy_o(busy)
`ifdef AMO_TIMEOUT_EN
    , .amo_timeout_o(amo_timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int wbv_cnt = 0;
  int first_wb_cyc = -1;
  int commit_cyc = 0;
  logic [63:0] last_wb = '0;

  bit check_en = 1'b1;
  bit exp_req = 1'b0, exp_pop = 1'b0, exp_wbv = 1'b0, exp_busy = 1'b0, exp_timeout = 1'b0;
  logic [3:0]  e_op = '0;
  logic [55:0] e_addr = '0;
  logic [63:0] e_data = '0, e_wb = '0;
  logic [1:0]  e_size = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] fmt(input logic [63:0] r, input logic [1:0] s);
    if (s == 2'b10) return 64'($signed(r[31:0]));
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare point, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("req", 64'(amo_req), 64'(exp_req));
      chk("pop", 64'(amo_pop), 64'(exp_pop));
      chk("wb_valid", 64'(wb_valid), 64'(exp_wbv));
      chk("busy", 64'(busy), 64'(exp_busy));
      if (exp_req) begin
        chk("req_op", 64'(amo_req_op), 64'(e_op));
        chk("req_addr", 64'(amo_req_addr), 64'(e_addr));
        chk("req_data", amo_req_data, e_data);
        chk("req_size", 64'(amo_req_size), 64'(e_size));
      end
      if (exp_wbv) chk("wb_data", wb_data, e_wb);
`ifdef AMO_TIMEOUT_EN
      chk("timeout", 64'(amo_timeout), 64'(exp_timeout));
`endif
    end
    if (amo_pop) pop_cnt++;
    if (wb_valid) begin
      wbv_cnt++;
      last_wb = wb_data;
      if (first_wb_cyc < 0) first_wb_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    exp_req = 1'b0; exp_pop = 1'b0; exp_wbv = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic finish_idle();
    step();
    amo_valid = 1'b0; commit = 1'b0; flush = 1'b0;
    amo_ack = 1'($urandom_range(0, 1)); amo_result = rnd64(); wb_ready = 1'($urandom_range(0, 1));
    idle_exp();
  endtask

  // fmode: 0 none, 1 flush in drain cycle fk, 2 flush in issue cycle fk.
  task automatic applyStimulus(input logic [3:0] op, input logic [55:0] addr, input logic [63:0] data,
                               input logic [1:0] size, input logic [63:0] res, input int d,
                               input int a, input int r, input int fmode, input int fk);
    bit killed = 1'b0;
    first_wb_cyc = -1;
    step();
    amo_valid = 1'b1; commit = 1'b1; flush = 1'b0;
    amo_op = op; amo_paddr = addr; amo_data = data; amo_size = size;
    amo_ack = 1'($urandom_range(0, 1)); amo_result = rnd64();
    pending_n = 1'($urandom_range(0, 1)); wb_ready = 1'($urandom_range(0, 1));
    idle_exp();
    commit_cyc = cyc;
    e_op = op; e_addr = addr; e_data = data; e_size = size; e_wb = fmt(res, size);
    for (int i = 0; i <= d; i++) begin
      step();
      commit = 1'b0; pending_n = (i == d); flush = (fmode == 1 && i == fk);
      amo_ack = 1'($urandom_range(0, 1)); amo_result = rnd64();
      exp_busy = 1'b1; exp_req = 1'b0; exp_wbv = 1'b0;
      exp_pop = (i == d) && (op == 4'd0) && !flush;
      if (flush || (i == d && op == 4'd0)) begin
        finish_idle();
        return;
      end
    end
    for (int j = 0; j <= a; j++) begin
      step();
      amo_op = 4'($urandom()); amo_paddr = 56'(rnd64()); amo_data = rnd64();
      amo_size = 2'($urandom()); pending_n = 1'($urandom_range(0, 1));
      flush = (fmode == 2 && j == fk);
      if (flush) killed = 1'b1;
      amo_ack = (j == a);
      amo_result = (j == a) ? res : rnd64();
      exp_req = 1'b1; exp_pop = (j == a); exp_busy = 1'b1; exp_wbv = 1'b0;
      if (j >= TMO) exp_timeout = 1'b1;
    end
    if (killed) begin
      step();
      amo_valid = 1'b0; flush = 1'($urandom_range(0, 1));
      amo_ack = 1'($urandom_range(0, 1)); wb_ready = 1'($urandom_range(0, 1));
      exp_req = 1'b0; exp_pop = 1'b0; exp_wbv = 1'b0; exp_busy = 1'b1;
    end else begin
      for (int k = 0; k <= r; k++) begin
        step();
        amo_valid = 1'b0; flush = 1'b0; amo_ack = 1'($urandom_range(0, 1)); amo_result = rnd64();
        wb_ready = (k == r);
        exp_req = 1'b0; exp_pop = 1'b0; exp_wbv = 1'b1; exp_busy = 1'b1;
      end
    end
    finish_idle();
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    chk(name, act, expv);
  endtask

  initial begin
    int p0, w0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic AMOADD.D, immediate ack: data three cycles after commit.
    applyStimulus(4'h4, 56'h8000_0040, 64'd5, 2'b11, 64'h7, 0, 0, 0, 0, 0);
    checkOutput("basic_wb_data", last_wb, 64'h7);
    checkOutput("basic_latency", 64'(first_wb_cyc - commit_cyc), 64'd3);

    applyStimulus(4'h3, 56'h1000, 64'h1, 2'b10, 64'h0000_0000_8000_0001, 0, 1, 0, 0, 0);
    checkOutput("word_sext", last_wb, 64'hFFFF_FFFF_8000_0001);

    applyStimulus(4'h4, 56'h2000, 64'h9, 2'b11, 64'h55, 10, 0, 0, 0, 0);

    p0 = pop_cnt; w0 = wbv_cnt;
    applyStimulus(4'h4, 56'h3000, 64'h9, 2'b11, 64'h66, 3, 0, 0, 1, 1);
    checkOutput("flush_drain_pops", 64'(pop_cnt - p0), 64'd0);
    checkOutput("flush_drain_wbv", 64'(wbv_cnt - w0), 64'd0);

    p0 = pop_cnt; w0 = wbv_cnt;
    applyStimulus(4'h4, 56'h4000, 64'h9, 2'b11, 64'h77, 0, 4, 0, 2, 0);
    checkOutput("flush_issue_pops", 64'(pop_cnt - p0), 64'd1);
    checkOutput("flush_issue_wbv", 64'(wbv_cnt - w0), 64'd0);

    w0 = wbv_cnt;
    applyStimulus(4'h4, 56'h5000, 64'h9, 2'b11, 64'hABCD, 0, 0, 5, 0, 0);
    checkOutput("backpressure_wbv_cycles", 64'(wbv_cnt - w0), 64'd6);

    applyStimulus(4'h0, 56'h6000, 64'h9, 2'b11, 64'h0, 2, 0, 0, 0, 0);

    // Asynchronous reset while the request is outstanding: dropped, no pop.
    p0 = pop_cnt;
    step();
    amo_valid = 1'b1; commit = 1'b1; amo_op = 4'h4; amo_paddr = 56'h7000; amo_data = 64'h3;
    amo_size = 2'b11; amo_ack = 1'b0; idle_exp();
    e_op = 4'h4; e_addr = 56'h7000; e_data = 64'h3; e_size = 2'b11;
    step();
    commit = 1'b0; pending_n = 1'b1; exp_busy = 1'b1;
    step();
    exp_req = 1'b1;
    #2;
    rst_n = 1'b0; amo_ack = 1'b1; idle_exp(); exp_timeout = 1'b0;
    step();
    step();
    rst_n = 1'b1; amo_valid = 1'b0; amo_ack = 1'b0;
    step();
    checkOutput("reset_no_pop", 64'(pop_cnt - p0), 64'd0);

    for (int n = 0; n < 150; n++) begin
      int d, a, fm, fk;
      logic [3:0] op;
      d  = $urandom_range(0, 4);
      a  = $urandom_range(0, 5);
      fm = $urandom_range(0, 5);
      fm = (fm == 4) ? 1 : (fm == 5) ? 2 : 0;
      fk = (fm == 1) ? $urandom_range(0, d) : (fm == 2) ? $urandom_range(0, a) : 0;
      op = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
      applyStimulus(op, 56'(rnd64()), rnd64(), $urandom_range(0, 1) ? 2'b10 : 2'b11, rnd64(),
                    d, a, $urandom_range(0, 3), fm, fk);
      repeat ($urandom_range(0, 2)) begin
        step();
        flush = 1'($urandom_range(0, 1)); amo_ack = 1'($urandom_range(0, 1));
      end
      flush = 1'b0;
    end

`ifdef AMO_TIMEOUT_EN
    applyStimulus(4'h4, 56'h9000, 64'h1, 2'b11, 64'h42, 0, 12, 0, 0, 0);
    checkOutput("timeout_sticky", 64'(amo_timeout), 64'd1);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
